shared_state_arbiter: RTL
=========================

Name: shared_state_arbiter

Overview:
Arbitrates write access from NREQ requesters to one shared sequential state register. Each requester can drive the same storage element, so every clock edge must resolve to exactly one writer (or none). Conflicts are resolved round-robin, with an optional bounded lock for multi-cycle ownership. The block also reports contention, for use as the sequencing front-end of any multi-driver state element in the design.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 1, width of the shared state register
MAX_LOCK, 4, max consecutive locked cycles before forced release (>=1)
CNT_W, 8, width of the saturating conflict counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester write request, level-sampled at posedge clk
lock  input  NREQ  per-requester ownership hold; meaningful only with req of same index
wdata  input  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH]
q  output  WIDTH  shared state register
gnt  output  NREQ  registered one-hot grant for the write performed at the last edge; all-zero = no write
conflict  output  1  registered pulse: >=2 req bits were high at the last edge
conflict_cnt  output  CNT_W  saturating count of conflict edges
locked  output  1  registered; high while in LOCKED state

Behaviour:
- Reset (async assert, sync-to-clk deassert by the environment): q=0, gnt=0, conflict=0, conflict_cnt=0, locked=0, rr pointer=0, state IDLE, lock-inhibit mask=0, lock counter=0.
- States: IDLE (no current owner), GRANT (single-cycle winner), LOCKED (owner holds).
- Arbitration (IDLE/GRANT): at each edge, winner = first i with req[i], scanning from pointer upward, mod NREQ.
  - q <= wdata[winner]; gnt <= onehot(winner); pointer <= (winner+1) mod NREQ.
  - Latency: data applied at edge k is visible on q and gnt immediately after edge k (0 wait).
  - If no req: gnt <= 0, q holds, pointer holds, state IDLE.
  - Enter LOCKED if lock[winner] & req[winner] & !inhibit[winner]. Lock counter <= 1. Otherwise enter GRANT.
- LOCKED, owner o:
  - If req[o]: winner = o regardless of other reqs; q <= wdata[o]; gnt <= onehot(o); pointer unchanged; lock counter +1.
  - Release when lock[o]=0, req[o]=0, or the lock counter reaches MAX_LOCK.
    - On release by req[o]=0: same edge performs normal arbitration among the others.
    - On release with req[o]=1 and lock[o]=0: o gets this write; pointer <= o+1; state GRANT.
    - Forced release (counter==MAX_LOCK, owner still asserting lock): the owner's write at this edge completes. Pointer <= o+1, inhibit[o] <= 1, state GRANT.
- inhibit[i] clears at any edge where req[i]=0. While set, lock[i] is ignored and i is arbitrated as a plain requester.
- Total writes by o in one lock episode = MAX_LOCK.
- conflict <= (popcount(req) >= 2) at every edge, all states. conflict_cnt increments on such edges and saturates at 2^CNT_W-1 (no wrap).
- gnt is always one-hot or zero. q never changes on an edge where gnt is set to 0.
- Reset mid-LOCKED aborts ownership. The first post-reset arbitration starts from pointer 0.

Test Plan:
- Reset: assert rst mid-cycle with req=4'b1111 -> q=0, gnt=0, conflict_cnt=0 immediately, without waiting for an edge.
- Single requester: req=4'b0100, wdata[2]=1 for 1 edge -> gnt=4'b0100, q=1, conflict=0; next edge req=0 -> gnt=0, q stays 1.
- Round-robin: req=4'b1111 held 5 edges, NREQ=4 -> gnt sequence 0001,0010,0100,1000,0001; conflict=1 each edge; conflict_cnt=5.
- Lock with forced release: MAX_LOCK=4; req=4'b0011, lock=4'b0001 held -> gnt=0001 for 4 edges, locked=1, then gnt=0010. Next edge gnt=0001 and locked stays 0 (inhibited). After req[0] drops one edge and re-asserts with lock, lock is honoured again.
- Saturation: CNT_W=3, req=4'b1010 for 10 edges -> conflict_cnt reaches 7 and holds at 7.
- Async reset mid-lock: while LOCKED on requester 1, pulse rst between edges -> locked=0, gnt=0, q=0. First edge after with req=4'b0110 grants 0010 (pointer 0 scan).

Source files
------------

// File: rtl/shared_state_arbiter.sv
// Round-robin write arbiter for one shared state register. It supports bounded
// multi-cycle lock ownership and keeps a saturating contention counter.
module shared_state_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 1,
  parameter int MAX_LOCK = 4,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]        q,
  output logic [NREQ-1:0]         gnt,
  output logic                    conflict,
  output logic [CNT_W-1:0]        conflict_cnt,
  output logic                    locked
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [NREQ-1:0] inhibit;
  logic [LW-1:0]   lock_cnt;

  logic            arb_found;
  logic [PW-1:0]   arb_win;
  logic            use_owner;
  logic            sel_found;
  logic [PW-1:0]   sel;
  logic            hold_lock;
  logic            force_rel;
  logic            new_lock;
  logic            new_lock_ok;
  logic            new_force;

  function automatic logic multi_req(input logic [NREQ-1:0] r);
    int n;
    n = 0;
    for (int i = 0; i < NREQ; i++)
      if (r[i]) n++;
    return n >= 2;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
  endfunction

  // Scan from the pointer upward; iterating downward lets the nearest hit win.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        arb_found = 1'b1;
        arb_win   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    use_owner   = (state == LOCKED) && req[owner];
    sel_found   = use_owner || arb_found;
    sel         = use_owner ? owner : arb_win;
    hold_lock   = use_owner && lock[owner] && (lock_cnt < LW'(MAX_LOCK - 1));
    force_rel   = use_owner && lock[owner] && !hold_lock;
    new_lock    = !use_owner && arb_found && lock[arb_win] && !inhibit[arb_win];
    // With MAX_LOCK==1 the entry write already exhausts the episode.
    new_lock_ok = new_lock && (MAX_LOCK > 1);
    new_force   = new_lock && (MAX_LOCK == 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      inhibit      <= '0;
      lock_cnt     <= '0;
      q            <= '0;
      gnt          <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      locked       <= 1'b0;
    end else begin
      conflict <= multi_req(req);
      if (multi_req(req))
        conflict_cnt <= sat_inc(conflict_cnt);

      inhibit <= (inhibit & req) | ((force_rel || new_force) ? onehot(sel) : '0);

      if (sel_found) begin
        q   <= wdata[int'(sel)*WIDTH +: WIDTH];
        gnt <= onehot(sel);
      end else begin
        gnt <= '0;
      end

      if (hold_lock) begin
        state    <= LOCKED;
        lock_cnt <= lock_cnt + LW'(1);
        locked   <= 1'b1;
      end else if (new_lock_ok) begin
        state    <= LOCKED;
        owner    <= arb_win;
        lock_cnt <= LW'(1);
        locked   <= 1'b1;
        ptr      <= next_ptr(arb_win);
      end else if (sel_found) begin
        state    <= GRANT;
        lock_cnt <= '0;
        locked   <= 1'b0;
        ptr      <= next_ptr(sel);
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule
